// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with a fixed wait.
// Optional macro MEM_RESPONDER_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [1:0]  iReqSize,
    input  logic        iReqUnsigned,
    input  logic [31:0] iReqAddr,
    input  logic [31:0] iReqWData,
    output logic        oRspValid,
    input  logic        iRspReady,
    output logic [31:0] oRspRData,
    output logic        oRspErr
);

    // state | meaning
    // IDLE  | ready for a request (oReqReady=1 once out of reset)
    // WAIT  | request captured, down-counting the wait cycles
    // RESP  | response presented, held until iRspReady
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t      state;
    logic [3:0]  wait_cnt;

    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        mem_we;

    logic        cur_write;
    logic [1:0]  cur_size;
    logic        cur_unsigned;
    logic [AW+1:0] cur_addr;
    logic [31:0] cur_wdata;

    logic [1:0]  off;
    logic        err;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] lane;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_data;
    logic [31:0] rsp_data;

    // Upper address bits wrap around and are deliberately dropped.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^iReqAddr[31:AW+2];

    assign accept = iReqValid && oReqReady;

    // With no wait the access happens on the accept edge, so decode the live inputs in IDLE.
    always_comb begin
        cur_write    = req_write;
        cur_size     = req_size;
        cur_unsigned = req_unsigned;
        cur_addr     = req_addr;
        cur_wdata    = req_wdata;
        if (state == IDLE) begin
            cur_write    = iReqWrite;
            cur_size     = iReqSize;
            cur_unsigned = iReqUnsigned;
            cur_addr     = iReqAddr[AW+1:0];
            cur_wdata    = iReqWData;
        end
    end

    always_comb begin
        off = cur_addr[1:0];
        err = (cur_size == 2'b11);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if ((cur_size == 2'b01) && cur_addr[0])
            err = 1'b1;
        if ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00))
            err = 1'b1;
`else
        if (cur_size == 2'b01)
            off[0] = 1'b0;
        if (cur_size == 2'b10)
            off = 2'b00;
`endif
    end

    assign idx = cur_addr[AW+1:2];

    always_comb begin
        be   = 4'b0000;
        lane = cur_wdata;
        case (cur_size)
            2'b00: begin
                be   = 4'b0001 << off;
                lane = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << off;
                lane = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                be   = 4'b1111;
                lane = cur_wdata;
            end
            default: begin
                be   = 4'b0000;
                lane = cur_wdata;
            end
        endcase
    end

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {off, 3'b000};

    always_comb begin
        load_data = 32'd0;
        case (cur_size)
            2'b00: load_data = cur_unsigned ? {24'd0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01: load_data = cur_unsigned ? {16'd0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            2'b10: load_data = rd_shift;
            default: load_data = 32'd0;
        endcase
    end

    assign rsp_data = (err || cur_write) ? 32'd0 : load_data;

    assign enter_resp = ((state == IDLE) && accept && NO_WAIT) ||
                        ((state == WAIT) && (wait_cnt == 4'd1));
    assign mem_we     = enter_resp && cur_write && !err;

    // Storage is intentionally not reset; a reset before commit leaves it untouched.
    always_ff @(posedge iClk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b])
                mem[idx][8*b +: 8] <= lane[8*b +: 8];
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            oReqReady    <= 1'b0;
            oRspValid    <= 1'b0;
            oRspRData    <= 32'd0;
            oRspErr      <= 1'b0;
            req_write    <= 1'b0;
            req_size     <= 2'b00;
            req_unsigned <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    oReqReady <= 1'b1;
                    if (accept) begin
                        req_write    <= iReqWrite;
                        req_size     <= iReqSize;
                        req_unsigned <= iReqUnsigned;
                        req_addr     <= iReqAddr[AW+1:0];
                        req_wdata    <= iReqWData;
                        oReqReady    <= 1'b0;
                        if (NO_WAIT) begin
                            state     <= RESP;
                            oRspValid <= 1'b1;
                            oRspRData <= rsp_data;
                            oRspErr   <= err;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= RESP;
                        oRspValid <= 1'b1;
                        oRspRData <= rsp_data;
                        oRspErr   <= err;
                    end
                end
                RESP: begin
                    if (iRspReady) begin
                        state     <= IDLE;
                        oReqReady <= 1'b1;
                        oRspValid <= 1'b0;
                        oRspRData <= 32'd0;
                        oRspErr   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    oReqReady <= 1'b0;
                    oRspValid <= 1'b0;
                    oRspRData <= 32'd0;
                    oRspErr   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a byte-array reference model.
// Honours MEM_RESPONDER_ALIGN_CHECK_EN the same way the design does.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWrite;
    logic [1:0]  iReqSize;
    logic        iReqUnsigned;
    logic [31:0] iReqAddr;
    logic [31:0] iReqWData;
    logic        oRspValid;
    logic        iRspReady;
    logic [31:0] oRspRData;
    logic        oRspErr;

    int tests = 0;
    int fails = 0;

    logic [7:0] mbytes [4*DEPTH];

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .iClk(iClk), .iRstN(iRstN),
        .iReqValid(iReqValid), .oReqReady(oReqReady),
        .iReqWrite(iReqWrite), .iReqSize(iReqSize), .iReqUnsigned(iReqUnsigned),
        .iReqAddr(iReqAddr), .iReqWData(iReqWData),
        .oRspValid(oRspValid), .iRspReady(iRspReady),
        .oRspRData(oRspRData), .oRspErr(oRspErr)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory viewed as bytes; accesses are naturally aligned byte runs.
    function automatic void model(input bit wr, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output bit err);
        int nbytes;
        int base;
        logic [31:0] v;
        logic [31:0] mask;
        rd  = 32'd0;
        err = 1'b0;
        if (sz == 2'b11) begin
            err = 1'b1;
            return;
        end
        nbytes = 1 << sz;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if ((addr % nbytes) != 0) begin
            err = 1'b1;
            return;
        end
`endif
        base = int'(addr % (4*DEPTH));
        base = base - (base % nbytes);
        if (wr) begin
            for (int i = 0; i < nbytes; i++)
                mbytes[base+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nbytes; i++)
                v[8*i +: 8] = mbytes[base+i];
            if (nbytes < 4 && !uns && v[8*nbytes-1]) begin
                mask = (32'd1 << (8*nbytes)) - 32'd1;
                v = v | ~mask;
            end
            rd = v;
        end
    endfunction

    task automatic scramble();
        iReqValid    = 1'($urandom);
        iReqWrite    = 1'($urandom);
        iReqSize     = 2'($urandom);
        iReqUnsigned = 1'($urandom);
        iReqAddr     = $urandom;
        iReqWData    = $urandom;
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input string tag, output logic [31:0] rd_obs);
        logic [31:0] exp_d;
        bit          exp_e;
        int          n;
        model(wr, sz, uns, addr, wd, exp_d, exp_e);
        @(negedge iClk);
        iReqValid = 1'b1; iReqWrite = wr; iReqSize = sz; iReqUnsigned = uns;
        iReqAddr = addr; iReqWData = wd; iRspReady = 1'b0;
        n = 0;
        while (oReqReady !== 1'b1 && n < 20) begin
            @(negedge iClk);
            n++;
        end
        check($sformatf("%s_req_ready", tag), 32'(oReqReady), 32'd1);
        @(negedge iClk);
        scramble();
        n = 1;
        while (oRspValid !== 1'b1 && n < 40) begin
            check($sformatf("%s_ready_low_wait", tag), 32'(oReqReady), 32'd0);
            @(negedge iClk);
            scramble();
            n++;
        end
        check($sformatf("%s_latency", tag), 32'(n), 32'(WAITC + 1));
        check($sformatf("%s_rdata", tag), oRspRData, exp_d);
        check($sformatf("%s_err", tag), 32'(oRspErr), 32'(exp_e));
        rd_obs = oRspRData;
        for (int i = 0; i < hold; i++) begin
            @(negedge iClk);
            scramble();
            check($sformatf("%s_hold_valid", tag), 32'(oRspValid), 32'd1);
            check($sformatf("%s_hold_rdata", tag), oRspRData, exp_d);
            check($sformatf("%s_hold_err", tag), 32'(oRspErr), 32'(exp_e));
            check($sformatf("%s_hold_ready", tag), 32'(oReqReady), 32'd0);
        end
        iRspReady = 1'b1;
        @(negedge iClk);
        iRspReady = 1'b0;
        iReqValid = 1'b0;
        check($sformatf("%s_done_valid", tag), 32'(oRspValid), 32'd0);
        check($sformatf("%s_done_ready", tag), 32'(oReqReady), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [1:0]  sz;

        iRstN = 1'b0; iReqValid = 1'b0; iReqWrite = 1'b0; iReqSize = 2'b00;
        iReqUnsigned = 1'b0; iReqAddr = 32'd0; iReqWData = 32'd0; iRspReady = 1'b0;

        repeat (3) @(negedge iClk);
        check("rst_ready", 32'(oReqReady), 32'd0);
        check("rst_valid", 32'(oRspValid), 32'd0);
        check("rst_rdata", oRspRData, 32'd0);
        check("rst_err", 32'(oRspErr), 32'd0);
        iRstN = 1'b1;
        #1;
        check("rst_release_ready_before_edge", 32'(oReqReady), 32'd0);
        @(negedge iClk);
        check("rst_release_ready_after_edge", 32'(oReqReady), 32'd1);

        for (int w = 0; w < 64; w++)
            do_req(1'b1, 2'b10, 1'b0, 32'(w*4), $urandom, 0, "init", rd);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sw_10", rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, "lw_10", rd);
        check("lw_10_literal", rd, 32'hDEADBEEF);

        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h80, 0, "sb_21", rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, "lb_21", rd);
        check("lb_21_literal", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, "lbu_21", rd);
        check("lbu_21_literal", rd, 32'h00000080);
        do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0, "lbu_20", rd);
        do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 0, "lbu_22", rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0, "lb_23", rd);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, "lh_20", rd);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, "hold5", rd);

        do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hA5A55A5A, 0, "sw_1000", rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, "lw_alias_0", rd);
        check("lw_alias_0_literal", rd, 32'hA5A55A5A);
        do_req(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 0, "lw_1002", rd);
        do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 0, "size11_store", rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, "after_size11", rd);
        check("after_size11_literal", rd, 32'hA5A55A5A);
        do_req(1'b1, 2'b01, 1'b0, 32'h33, 32'h0000BEEF, 0, "sh_33", rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, "lw_30", rd);

        // Reset while a store is waiting: it must never be committed.
        @(negedge iClk);
        iReqValid = 1'b1; iReqWrite = 1'b1; iReqSize = 2'b10; iReqUnsigned = 1'b0;
        iReqAddr = 32'h10; iReqWData = 32'h12345678;
        for (int n = 0; n < 20 && oReqReady !== 1'b1; n++)
            @(negedge iClk);
        check("abort_req_ready", 32'(oReqReady), 32'd1);
        @(negedge iClk);
        iReqValid = 1'b0;
        check("abort_in_wait", 32'(oRspValid), 32'd0);
        iRstN = 1'b0;
        #1;
        check("abort_ready", 32'(oReqReady), 32'd0);
        check("abort_valid", 32'(oRspValid), 32'd0);
        check("abort_rdata", oRspRData, 32'd0);
        check("abort_err", 32'(oRspErr), 32'd0);
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        check("abort_release_ready", 32'(oReqReady), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, "abort_reload", rd);
        check("abort_reload_literal", rd, 32'hDEADBEEF);

        for (int k = 0; k < 150; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom & 32'hFFFF_F0FF;
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 2)), "rand", rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the extra cycles inserted between request accept and response (0..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: iClk  input  1  rising-edge clock.
REQ-004 SHALL have iRstN  input  1  asynchronous active-low reset.
REQ-005 SHALL have iReqValid  input  1  request present.
REQ-006 SHALL have oReqReady  output  1  responder can accept a request.
REQ-007 SHALL have iReqWrite  input  1  1 = store, 0 = load.
REQ-008 SHALL have iReqSize  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 SHALL have iReqUnsigned  input  1  zero-extend load data (LBU/LHU).
REQ-010 SHALL have iReqAddr  input  32  byte address.
REQ-011 SHALL have iReqWData  input  32  store data, right-aligned.
REQ-012 SHALL have oRspValid  output  1  response present.
REQ-013 SHALL have iRspReady  input  1  requester accepts the response.
REQ-014 SHALL have oRspRData  output  32  extended load data (0 for stores and errors).
REQ-015 SHALL have oRspErr  output  1  request was illegal.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP; oReqReady SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on the rising edge where iReqValid && oReqReady, capturing all request fields into registers.
REQ-018 SHALL move on accept from IDLE to WAIT, or to RESP when WAIT_CYCLES == 0.
REQ-019 SHALL count WAIT_CYCLES cycles in WAIT with a down-counter and move to RESP on the edge where the count reaches 0.
REQ-020 SHALL assert oRspValid exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 SHALL perform the store on the edge entering RESP, using byte enables derived from size and addr[1:0] and lane-shifting the write data.
REQ-022 SHALL select the load word on entry to RESP, shift it by addr[1:0], and sign- or zero-extend it per iReqUnsigned.
REQ-023 SHALL hold oRspValid, oRspRData and oRspErr stable in RESP until iRspReady=1, then return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request on the same edge that a response completes; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-025 SHALL form the word index as addr[log2(DEPTH_WORDS)+1:2] and ignore higher address bits (wrap-around).
REQ-026 SHALL treat size 11 as an error: no store, oRspErr=1, oRspRData=0.
REQ-027 SHALL ignore request inputs that change while not in IDLE.

Reset
REQ-028 SHALL force, while iRstN=0, state IDLE, counter 0, oReqReady=0, oRspValid=0, oRspRData=0 and oRspErr=0; oReqReady SHALL rise on the first edge after deassertion.
REQ-029 SHALL abandon any in-flight request on reset; a store not yet committed SHALL NOT be written.
REQ-030 SHALL NOT reset storage contents.

Configuration
REQ-031 SHALL, with MEM_RESPONDER_ALIGN_CHECK_EN defined, flag a half access with addr[0]=1 or a word access with addr[1:0]!=0 as an error per REQ-026.
REQ-032 SHALL, without MEM_RESPONDER_ALIGN_CHECK_EN, force the offending low address bits to 0 and complete the access normally with oRspErr=0.

Verification
REQ-033 SHALL cover: reset, then store word 0xDEADBEEF to 0x10, then load word from 0x10 -> oRspRData=0xDEADBEEF, oRspValid 3 cycles after each accept.
REQ-034 SHALL cover: store byte 0x80 to 0x21, then LB from 0x21 -> 0xFFFFFF80; LBU from 0x21 -> 0x00000080; bytes at 0x20, 0x22 and 0x23 unchanged.
REQ-035 SHALL cover: hold iRspReady=0 for 5 cycles during RESP -> oRspValid and data stable, oReqReady=0 throughout.
REQ-036 SHALL cover: word load at 0x0000_1002 -> with macro, oRspErr=1 and data 0; without macro, data equals the word at 0x1000.
REQ-037 SHALL cover: store to 0x1000 (DEPTH 1024) aliases 0x0 -> load from 0x0 returns the stored data.
REQ-038 SHALL cover: assert iRstN=0 during WAIT of a store -> no write occurs, all outputs 0, and a subsequent load returns the old value.
